// File: rtl/card_hand.sv
// card_hand: draws a dealt row of up to MAX_CARDS runtime-loaded cards over the VGA stream.
// Latency: hand_out lags hand_in by 3 clocks on every field; a load shows on card_count_o the next clock.
// Backpressure: card_ready_o drops while the hand is full or a clear is waiting for the next frame boundary.
module card_hand #(
   parameter int          HAND_XPOS    = 20,
   parameter int          HAND_YPOS    = 30,
   parameter int          MAX_CARDS    = 6,
   parameter int          CARD_WIDTH   = 64,
   parameter int          CARD_HEIGHT  = 96,
   parameter int          CARD_SPACING = 48,
   parameter logic [11:0] BACK_RGB     = 12'h236,
   localparam int         CNT_W        = $clog2(MAX_CARDS + 1)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   // stream from the previous stage
   input  logic [10:0]      hand_in_vcount_i,
   input  logic             hand_in_vsync_i,
   input  logic             hand_in_vblnk_i,
   input  logic [10:0]      hand_in_hcount_i,
   input  logic             hand_in_hsync_i,
   input  logic             hand_in_hblnk_i,
   input  logic [11:0]      hand_in_rgb_i,
   // stream to the next stage
   output logic [10:0]      hand_out_vcount_o,
   output logic             hand_out_vsync_o,
   output logic             hand_out_vblnk_o,
   output logic [10:0]      hand_out_hcount_o,
   output logic             hand_out_hsync_o,
   output logic             hand_out_hblnk_o,
   output logic [11:0]      hand_out_rgb_o,
   // card load port
   input  logic             card_valid_i,
   output logic             card_ready_o,
   input  logic [3:0]       card_number_i,
   input  logic [1:0]       card_symbol_i,
   input  logic             card_face_up_i,
   input  logic             hand_clear_i,
   input  logic             reveal_all_i,
   output logic [CNT_W-1:0] card_count_o,
   output logic             hand_full_o,
   // shared card image ROM (one clock read latency)
   output logic [12:0]      rom_addr_o,
   output logic [3:0]       rom_number_o,
   output logic [1:0]       rom_symbol_o,
   input  logic [11:0]      rom_rgb_i
);

   typedef struct packed {
      logic [10:0] vcount;
      logic        vsync;
      logic        vblnk;
      logic [10:0] hcount;
      logic        hsync;
      logic        hblnk;
      logic [11:0] rgb;
   } vga_t;

   // left edge of slot i
   function automatic int slot_x(input int i);
      return HAND_XPOS + i * CARD_SPACING;
   endfunction

   vga_t             in_s, d1_q, d2_q, out_q;
   logic [CNT_W-1:0] count_q, shown_q;
   logic             clear_pend_q;
   logic             vblnk_prev_q;
   logic [3:0]       num_q [MAX_CARDS];
   logic [1:0]       sym_q [MAX_CARDS];
   logic [MAX_CARDS-1:0] up_q;

   logic             frame_edge;
   logic             accept;
   logic             y_in;
   logic             hit_d, up_d;
   logic [3:0]       num_d;
   logic [1:0]       sym_d;
   int               xl_d;
   logic [12:0]      addr_d;
   logic             hit1_q, face1_q, hit2_q, face2_q;

   assign in_s = {hand_in_vcount_i, hand_in_vsync_i, hand_in_vblnk_i,
                  hand_in_hcount_i, hand_in_hsync_i, hand_in_hblnk_i, hand_in_rgb_i};

   assign frame_edge   = hand_in_vblnk_i && !vblnk_prev_q;
   assign card_ready_o = (count_q < CNT_W'(MAX_CARDS)) && !clear_pend_q;
   assign accept       = card_valid_i && card_ready_o && !hand_clear_i;
   assign card_count_o = count_q;
   assign hand_full_o  = (count_q == CNT_W'(MAX_CARDS));

   // Hand bookkeeping: loads, clear, reveal, and latching the drawn count at the frame boundary.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         count_q      <= '0;
         shown_q      <= '0;
         clear_pend_q <= 1'b0;
         vblnk_prev_q <= 1'b0;
         up_q         <= '0;
         for (int i = 0; i < MAX_CARDS; i++) begin
            num_q[i] <= '0;
            sym_q[i] <= '0;
         end
      end else begin
         vblnk_prev_q <= hand_in_vblnk_i;
         // count_q here is the pre-clear value, so a coincident clear still shows the old hand this frame
         if (frame_edge) begin
            shown_q      <= count_q;
            clear_pend_q <= 1'b0;
         end
         // a clear overrides both the load and a coincident frame-boundary release
         if (hand_clear_i) begin
            count_q      <= '0;
            clear_pend_q <= 1'b1;
         end else if (accept) begin
            count_q <= count_q + CNT_W'(1);
         end
         if (reveal_all_i) begin
            up_q <= '1;
         end
         for (int i = 0; i < MAX_CARDS; i++) begin
            if (accept && (count_q == CNT_W'(i))) begin
               num_q[i] <= card_number_i;
               sym_q[i] <= card_symbol_i;
               up_q[i]  <= card_face_up_i || reveal_all_i;
            end
         end
      end
   end

   // Hit test over the shown slots; the highest index wins so later cards sit on top.
   always_comb begin
      hit_d  = 1'b0;
      up_d   = 1'b0;
      num_d  = '0;
      sym_d  = '0;
      xl_d   = 0;
      addr_d = '0;
      y_in   = (int'(in_s.vcount) >= HAND_YPOS) &&
               (int'(in_s.vcount) <  HAND_YPOS + CARD_HEIGHT);
      for (int i = 0; i < MAX_CARDS; i++) begin
         if ((CNT_W'(i) < shown_q) && y_in &&
             (int'(in_s.hcount) >= slot_x(i)) &&
             (int'(in_s.hcount) <  slot_x(i) + CARD_WIDTH)) begin
            hit_d = 1'b1;
            up_d  = up_q[i];
            num_d = num_q[i];
            sym_d = sym_q[i];
            xl_d  = slot_x(i);
         end
      end
      if (hit_d) begin
         addr_d = 13'((int'(in_s.vcount) - HAND_YPOS) * CARD_WIDTH + (int'(in_s.hcount) - xl_d));
      end
   end

   // Stage 1: register timing, hit info and the ROM request.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         d1_q         <= '0;
         hit1_q       <= 1'b0;
         face1_q      <= 1'b0;
         rom_addr_o   <= '0;
         rom_number_o <= '0;
         rom_symbol_o <= '0;
      end else begin
         d1_q         <= in_s;
         hit1_q       <= hit_d;
         face1_q      <= up_d && (num_d >= 4'd1) && (num_d <= 4'd13);
         rom_addr_o   <= addr_d;
         rom_number_o <= num_d;
         rom_symbol_o <= sym_d;
      end
   end

   // Stage 2: wait out the ROM read latency.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         d2_q    <= '0;
         hit2_q  <= 1'b0;
         face2_q <= 1'b0;
      end else begin
         d2_q    <= d1_q;
         hit2_q  <= hit1_q;
         face2_q <= face1_q;
      end
   end

   // Stage 3: choose background, card face or card back and register the output stream.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         out_q <= '0;
      end else begin
         out_q <= d2_q;
         if (hit2_q && !d2_q.hblnk && !d2_q.vblnk) begin
            out_q.rgb <= face2_q ? rom_rgb_i : BACK_RGB;
         end
      end
   end

   assign hand_out_vcount_o = out_q.vcount;
   assign hand_out_vsync_o  = out_q.vsync;
   assign hand_out_vblnk_o  = out_q.vblnk;
   assign hand_out_hcount_o = out_q.hcount;
   assign hand_out_hsync_o  = out_q.hsync;
   assign hand_out_hblnk_o  = out_q.hblnk;
   assign hand_out_rgb_o    = out_q.rgb;

endmodule

// File: tb/tb_card_hand.sv
// tb_card_hand: directed pixel-by-pixel stimulus; expected output tuples queued at drive time
// and compared 3 clocks later; control outputs and ROM requests checked against constants.
module tb_card_hand;

   localparam logic [11:0] BG   = 12'h0A0;
   localparam logic [11:0] VB   = 12'h0F0;
   localparam logic [11:0] BACK = 12'h236;

   logic        clk = 1'b0;
   logic        rst;
   logic [10:0] in_vc, in_hc, out_vc, out_hc;
   logic        in_vs, in_vb, in_hs, in_hb, out_vs, out_vb, out_hs, out_hb;
   logic [11:0] in_rgb, out_rgb;
   logic        card_valid, card_ready, card_face_up, hand_clear, reveal_all, hand_full;
   logic [3:0]  card_number, rom_number;
   logic [1:0]  card_symbol, rom_symbol;
   logic [2:0]  card_count;
   logic [12:0] rom_addr;
   logic [11:0] rom_rgb;

   always #5 clk = ~clk;

   card_hand dut (
      .clk_i(clk), .rst_i(rst),
      .hand_in_vcount_i(in_vc), .hand_in_vsync_i(in_vs), .hand_in_vblnk_i(in_vb),
      .hand_in_hcount_i(in_hc), .hand_in_hsync_i(in_hs), .hand_in_hblnk_i(in_hb),
      .hand_in_rgb_i(in_rgb),
      .hand_out_vcount_o(out_vc), .hand_out_vsync_o(out_vs), .hand_out_vblnk_o(out_vb),
      .hand_out_hcount_o(out_hc), .hand_out_hsync_o(out_hs), .hand_out_hblnk_o(out_hb),
      .hand_out_rgb_o(out_rgb),
      .card_valid_i(card_valid), .card_ready_o(card_ready),
      .card_number_i(card_number), .card_symbol_i(card_symbol), .card_face_up_i(card_face_up),
      .hand_clear_i(hand_clear), .reveal_all_i(reveal_all),
      .card_count_o(card_count), .hand_full_o(hand_full),
      .rom_addr_o(rom_addr), .rom_number_o(rom_number), .rom_symbol_o(rom_symbol),
      .rom_rgb_i(rom_rgb)
   );

   // card image ROM stand-in: synchronous, data is a hash of the request
   function automatic logic [11:0] rom_f(input logic [12:0] a, input logic [3:0] n, input logic [1:0] s);
      return a[11:0] ^ {n, s, 6'h15};
   endfunction

   always @(posedge clk) rom_rgb <= rom_f(rom_addr, rom_number, rom_symbol);

   typedef struct packed {
      logic        zero;
      logic [10:0] vc;
      logic        vs;
      logic        vb;
      logic [10:0] hc;
      logic        hs;
      logic        hb;
      logic [11:0] rgb;
   } exp_t;

   exp_t  sb[$];
   string tq[$];
   int    nvec = 0;
   int    nerr = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // drive one pixel, queue its expected output, compare the output due this cycle
   task automatic pix(input int hc, input int vc, input logic hb, input logic vb,
                      input logic [11:0] rin, input logic [11:0] exp_rgb, input string tag);
      exp_t e;
      exp_t p;
      string t;
      in_hc  = 11'(hc);
      in_vc  = 11'(vc);
      in_hb  = hb;
      in_vb  = vb;
      in_hs  = (hc % 3 == 0);
      in_vs  = vb ^ (vc % 2 == 1);
      in_rgb = rin;
      e.zero = rst;
      e.vc   = in_vc;
      e.vs   = in_vs;
      e.vb   = in_vb;
      e.hc   = in_hc;
      e.hs   = in_hs;
      e.hb   = in_hb;
      e.rgb  = exp_rgb;
      if (rst) begin
         for (int i = 0; i < sb.size(); i++) sb[i].zero = 1'b1;
      end
      sb.push_back(e);
      tq.push_back(tag);
      @(posedge clk);
      #1;
      if (sb.size() == 3) begin
         p = sb.pop_front();
         t = tq.pop_front();
         chk(t, 64'({out_vc, out_vs, out_vb, out_hc, out_hs, out_hb, out_rgb}),
                p.zero ? 64'd0 : 64'({p.vc, p.vs, p.vb, p.hc, p.hs, p.hb, p.rgb}));
      end
   endtask

   task automatic frame();
      pix(0, 130, 1'b1, 1'b1, VB, VB, "vblank0");
      pix(1, 130, 1'b1, 1'b1, VB, VB, "vblank1");
   endtask

   task automatic load(input logic [3:0] n, input logic [1:0] s, input logic up);
      card_valid   = 1'b1;
      card_number  = n;
      card_symbol  = s;
      card_face_up = up;
      pix(0, 0, 1'b0, 1'b0, BG, BG, "load_px");
      card_valid   = 1'b0;
   endtask

   int nums [5] = '{3, 10, 12, 13, 2};
   int syms [5] = '{1, 0, 3, 1, 2};

   initial begin
      rst = 1'b1; card_valid = 1'b0; card_number = '0; card_symbol = '0; card_face_up = 1'b0;
      hand_clear = 1'b0; reveal_all = 1'b0;
      in_vc = '0; in_hc = '0; in_vs = 1'b0; in_vb = 1'b0; in_hs = 1'b0; in_hb = 1'b0; in_rgb = '0;

      // reset
      repeat (3) pix(5, 5, 1'b0, 1'b0, BG, BG, "reset");
      rst = 1'b0;
      chk("rst_ready", card_ready, 1);
      chk("rst_count", card_count, 0);
      chk("rst_full", hand_full, 0);
      chk("rst_rom_addr", rom_addr, 0);

      // idle stream passes through
      for (int i = 0; i < 4; i++) pix(10 + i, 7, 1'b0, 1'b0, BG, BG, "idle");

      // mid-frame load: invisible until the next frame
      load(4'd7, 2'd2, 1'b1);
      chk("load_count", card_count, 1);
      pix(20, 30, 1'b0, 1'b0, BG, BG, "same_frame_origin");
      pix(83, 125, 1'b0, 1'b0, BG, BG, "same_frame_corner");
      frame();
      pix(20, 30, 1'b0, 1'b0, BG, rom_f(13'd0, 4'd7, 2'd2), "card0_origin");
      chk("origin_addr", rom_addr, 0);
      chk("origin_number", rom_number, 7);
      chk("origin_symbol", rom_symbol, 2);
      pix(83, 125, 1'b0, 1'b0, BG, rom_f(13'd6143, 4'd7, 2'd2), "card0_corner");
      chk("corner_addr", rom_addr, 6143);
      pix(84, 125, 1'b0, 1'b0, BG, BG, "right_edge");
      pix(83, 126, 1'b0, 1'b0, BG, BG, "bottom_edge");
      pix(19, 30, 1'b0, 1'b0, BG, BG, "left_edge");
      pix(20, 29, 1'b0, 1'b0, BG, BG, "top_edge");
      pix(40, 50, 1'b1, 1'b0, BG, BG, "hblank_in_card");

      // fill the hand, then a refused seventh load
      for (int k = 0; k < 5; k++) load(4'(nums[k]), 2'(syms[k]), 1'b1);
      load(4'd9, 2'd0, 1'b1);
      chk("full_count", card_count, 6);
      chk("full_flag", hand_full, 1);
      chk("full_ready", card_ready, 0);
      frame();
      pix(68, 30, 1'b0, 1'b0, BG, rom_f(13'd0, 4'd3, 2'd1), "overlap_slot1");
      chk("overlap_number", rom_number, 3);
      pix(67, 31, 1'b0, 1'b0, BG, rom_f(13'd111, 4'd7, 2'd2), "slot0_before_overlap");
      pix(270, 100, 1'b0, 1'b0, BG, rom_f(13'd4490, 4'd2, 2'd2), "overlap_slot5");

      // clear beats a coincident load; old hand stays drawn until the frame boundary
      hand_clear = 1'b1; card_valid = 1'b1; card_number = 4'd9;
      pix(68, 30, 1'b0, 1'b0, BG, rom_f(13'd0, 4'd3, 2'd1), "clear_px");
      hand_clear = 1'b0; card_valid = 1'b0;
      chk("clear_count", card_count, 0);
      chk("clear_ready", card_ready, 0);
      pix(20, 30, 1'b0, 1'b0, BG, rom_f(13'd0, 4'd7, 2'd2), "old_hand_visible");
      chk("clear_ready_hold", card_ready, 0);
      frame();
      chk("after_vblank_ready", card_ready, 1);
      chk("after_vblank_count", card_count, 0);
      pix(20, 30, 1'b0, 1'b0, BG, BG, "cleared_frame");

      // face-down ace, then reveal
      load(4'd1, 2'd0, 1'b0);
      chk("ace_count", card_count, 1);
      frame();
      pix(40, 50, 1'b0, 1'b0, BG, BACK, "face_down");
      reveal_all = 1'b1;
      pix(41, 50, 1'b0, 1'b0, BG, BACK, "reveal_px");
      reveal_all = 1'b0;
      pix(42, 50, 1'b0, 1'b0, BG, rom_f(13'd1302, 4'd1, 2'd0), "revealed");

      // invalid rank draws the back; reveal coinciding with a load stores it face-up
      load(4'd14, 2'd3, 1'b1);
      reveal_all = 1'b1;
      load(4'd5, 2'd1, 1'b0);
      reveal_all = 1'b0;
      chk("three_count", card_count, 3);
      frame();
      pix(100, 30, 1'b0, 1'b0, BG, BACK, "rank14_back");
      pix(150, 60, 1'b0, 1'b0, BG, rom_f(13'd1954, 4'd5, 2'd1), "reveal_with_load");

      // reset mid-row with three cards shown
      rst = 1'b1;
      pix(120, 40, 1'b0, 1'b0, BG, BG, "rst_px");
      rst = 1'b0;
      chk("midrst_rgb", out_rgb, 0);
      chk("midrst_count", card_count, 0);
      chk("midrst_ready", card_ready, 1);
      chk("midrst_full", hand_full, 0);
      chk("midrst_rom", 64'({rom_addr, rom_number, rom_symbol}), 0);
      pix(120, 40, 1'b0, 1'b0, BG, BG, "post_rst_row");
      frame();
      pix(20, 30, 1'b0, 1'b0, BG, BG, "post_rst_frame0");
      pix(150, 60, 1'b0, 1'b0, BG, BG, "post_rst_frame2");
      pix(0, 0, 1'b0, 1'b0, BG, BG, "drain0");
      pix(1, 0, 1'b0, 1'b0, BG, BG, "drain1");

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/card_hand.md
# card_hand

Renders a row of up to MAX_CARDS playing cards onto the VGA stream, with card faces chosen at runtime rather than fixed by parameters. It generalises the single fixed card renderer into a dealt-hand renderer for the player or dealer row. Cards are loaded through a valid/ready port, face-down cards show a back colour, and the visible card count updates only at frame boundaries so the picture never tears. It sits in the vga_if chain between the background and cursor/text stages and drives a shared synchronous card image ROM.

## Interface
- HAND_XPOS, 20: x of slot 0 left edge.
- HAND_YPOS, 30: y of the card row top edge.
- MAX_CARDS, 6: number of slots, 1..8.
- CARD_WIDTH, 64: card width in pixels.
- CARD_HEIGHT, 96: card height in pixels; CARD_WIDTH*CARD_HEIGHT ≤ 8192.
- CARD_SPACING, 48: x stride between slots; a value < CARD_WIDTH makes cards overlap.
- BACK_RGB, 12'h236: colour of face-down cards.

- clk  in  1  pixel clock.
- rst  in  1  synchronous, active-high reset.
- hand_in  vga_if.in  —  timing and rgb from the previous stage.
- hand_out  vga_if.out  —  timing and rgb to the next stage.
- card_valid  in  1  load request.
- card_ready  out  1  slot available; a load transfers when card_valid && card_ready.
- card_number  in  4  card rank 1..13.
- card_symbol  in  2  suit 0..3.
- card_face_up  in  1  face-up flag of the loaded card.
- hand_clear  in  1  one-cycle pulse that empties the hand.
- reveal_all  in  1  one-cycle pulse that sets every slot face-up.
- card_count  out  $clog2(MAX_CARDS+1)  cards loaded.
- hand_full  out  1  card_count == MAX_CARDS.
- rom_addr  out  13  pixel address within a card.
- rom_number  out  4  rank select for the ROM.
- rom_symbol  out  2  suit select for the ROM.
- rom_rgb  in  12  ROM data, valid one clock after the address.

## Operation
- Slot store: MAX_CARDS entries of {number, symbol, face_up}.
- Load: on card_valid && card_ready:
  - write slot[card_count];
  - card_count <= card_count + 1.
- card_ready = (card_count < MAX_CARDS) && !clear_pending. The outputs card_ready and hand_full are decoded from registers.
- hand_clear:
  - card_count <= 0 and clear_pending <= 1;
  - slots are left unchanged;
  - it beats a load in the same cycle, and that load is not accepted.
- reveal_all sets face_up in every slot. If it coincides with a load, the new card is stored face-up.
- Frame boundary, defined as hand_in.vblnk going 0→1 on the input:
  - shown_count <= card_count;
  - clear_pending <= 0.
- If the frame boundary and hand_clear happen in the same cycle, clear_pending stays 1 and shown_count takes the pre-clear card_count.
- Hit test for slot i < shown_count:
  - x in [HAND_XPOS + i*CARD_SPACING, that + CARD_WIDTH);
  - y in [HAND_YPOS, HAND_YPOS + CARD_HEIGHT).
- When slots overlap, the highest index wins, so a later card is drawn on top.
- rom_addr = (vcount − HAND_YPOS)*CARD_WIDTH + (hcount − slot x). Unsigned arithmetic, no wrap inside the hit region.
- Output rgb selection:
  - outside any hit, or during hblnk/vblnk: delayed hand_in.rgb;
  - hit, face-up, and rank in 1..13: rom_rgb;
  - hit and face-down, or rank 0/14/15: BACK_RGB.
- Reset values:
  - hand_out fields all 0;
  - rom_addr/rom_number/rom_symbol 0;
  - card_count, shown_count, clear_pending 0;
  - all slots 0, with face_up 0;
  - card_ready therefore reads 1 and hand_full 0.

## Timing
- Three-stage pipeline; hand_out lags hand_in by exactly 3 clocks on every field.
  - S1, registered: delayed timing, hit flag, slot data, rom_addr/number/symbol.
  - S2: the ROM returns rom_rgb while timing is delayed one more clock.
  - S3: the rgb mux result and timing go into the hand_out registers.
- A load is visible on card_count the next clock. It is drawn from the first frame after the next vblnk rise.
- rst mid-frame: all state returns to its reset values at the next edge, and the output stream is zero for 3 clocks.

## Test plan
- Reset, then idle stream with rgb 12'h0A0 → hand_out equals hand_in delayed 3 clocks; card_ready = 1, card_count = 0.
- Load (7, suit 2, face-up) mid-frame → card_count = 1 next clock.
  - Remainder of that frame has no card pixels.
  - Next frame at (20,30) has rom_number = 7, rom_symbol = 2, rom_addr = 0.
  - At (83,125), rom_addr = 6143.
- Load 6 cards, then a 7th valid → hand_full = 1, card_ready = 0, card_count stays 6. Slot 1 pixel at x = 68 (overlap region) shows slot 1, not slot 0.
- Load face-down ace → BACK_RGB at (40,50); reveal_all → ROM face data from the next pixel onward.
- hand_clear together with card_valid → card_count = 0, the load is not accepted, card_ready = 0 until the vblnk rise. The old cards stay visible until that frame boundary.
- Assert rst mid-row while shown_count = 3 → all outputs 0 next clock; the next frame draws no cards.
